// File: rtl/stk_pkg.sv
// -----------------------------------------------------------------------------
// stk_pkg -- shared types for the stk line-memory blocks.
//   line_id_t      : memory line address
//   line_data_t    : one memory line of LINE_DATA_W bits
//   wrarb_entry_t  : buffered pipeline write {addr, data}
//   wrarb_sel_e    : write-arbiter selection for the current cycle
// -----------------------------------------------------------------------------
package stk_pkg;

    localparam int unsigned LINE_ID_W   = 8;
    localparam int unsigned LINE_DATA_W = 128;

    typedef logic [LINE_ID_W-1:0]   line_id_t;
    typedef logic [LINE_DATA_W-1:0] line_data_t;

    typedef struct packed {
        line_id_t   addr;
        line_data_t data;
    } wrarb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_INIT = 2'd1,
        SEL_PIPE = 2'd2
    } wrarb_sel_e;

endpackage

// File: rtl/stk_pipe_al_wrarb_fifo.sv
// -----------------------------------------------------------------------------
// stk_pipe_al_wrarb_fifo -- in-order buffer for pipeline writes.
//   BUF_N      : depth, power of two, >= 2 (pointers wrap naturally)
//   clk/arst_n : clock, asynchronous active-low reset
//   push       : write push_entry at the tail
//   push_entry : entry to store
//   pop        : drop the head entry
//   head       : current head entry (valid while count != 0)
//   count      : registered occupancy, $clog2(BUF_N)+1 bits
// Storage is not reset; only pointers and occupancy are.
// -----------------------------------------------------------------------------
module stk_pipe_al_wrarb_fifo
    import stk_pkg::*;
#(
    parameter int unsigned BUF_N = 2
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     push,
    input  wrarb_entry_t             push_entry,
    input  logic                     pop,
    output wrarb_entry_t             head,
    output logic [$clog2(BUF_N):0]   count
);

    localparam int unsigned PTR_W = $clog2(BUF_N);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    wrarb_entry_t     mem [BUF_N];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/stk_pipe_al_wrarb.sv
// -----------------------------------------------------------------------------
// stk_pipe_al_wrarb -- memory write arbiter between the init engine and a
// buffered pipeline write port.
//   clk, arst_n          : clock, asynchronous active-low reset
//   i_init_wen_r/waddr/wdata : init-engine write (always wins, never delayed)
//   i_init_busy_r        : init active; buffered pipe writes are held
//   i_pipe_wr_vld/addr/data, o_pipe_wr_rdy : pipeline write handshake
//   o_mem_wen_r/waddr_r/wdata_r : registered bank write port
//   o_idle_r             : registered idle indication
// Optional (macro STK_AL_WRARB_STATS_EN):
//   o_stat_pipe_wr_r     : saturating count of issued pipeline writes
//   o_stat_stall_r       : saturating count of cycles a non-empty buffer waited
// -----------------------------------------------------------------------------
module stk_pipe_al_wrarb
    import stk_pkg::*;
#(
    parameter int unsigned BUF_N = 2
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   i_init_wen_r,
    input  line_id_t               i_init_waddr_r,
    input  logic [LINE_DATA_W-1:0] i_init_wdata_r,
    input  logic                   i_init_busy_r,
    input  logic                   i_pipe_wr_vld,
    input  line_id_t               i_pipe_wr_addr,
    input  logic [LINE_DATA_W-1:0] i_pipe_wr_data,
    output logic                   o_pipe_wr_rdy,
    output logic                   o_mem_wen_r,
    output line_id_t               o_mem_waddr_r,
    output logic [LINE_DATA_W-1:0] o_mem_wdata_r,
    output logic                   o_idle_r
`ifdef STK_AL_WRARB_STATS_EN
    ,
    output logic [31:0]            o_stat_pipe_wr_r,
    output logic [31:0]            o_stat_stall_r
`endif
);

    localparam int unsigned CNT_W = $clog2(BUF_N) + 1;

    logic             push;
    logic             pop;
    wrarb_entry_t     push_entry;
    wrarb_entry_t     head;
    logic [CNT_W-1:0] count;
    logic             fifo_nempty;
    wrarb_sel_e       sel;

    // Ready depends on registered occupancy only, so a full buffer refuses a
    // push even in a cycle where the head is popped.
    assign o_pipe_wr_rdy = (count < CNT_W'(BUF_N));
    assign push          = i_pipe_wr_vld & o_pipe_wr_rdy;
    assign push_entry    = '{addr: i_pipe_wr_addr, data: i_pipe_wr_data};
    // Occupancy is registered, so a write into an empty buffer only becomes
    // selectable the cycle after acceptance.
    assign fifo_nempty   = (count != '0);

    stk_pipe_al_wrarb_fifo #(
        .BUF_N (BUF_N)
    ) u_fifo (
        .clk        (clk),
        .arst_n     (arst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    always_comb begin
        sel = SEL_NONE;
        if (i_init_wen_r) begin
            sel = SEL_INIT;
        end else if (fifo_nempty && !i_init_busy_r) begin
            sel = SEL_PIPE;
        end
    end

    assign pop = (sel == SEL_PIPE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_mem_wen_r   <= 1'b0;
            o_mem_waddr_r <= '0;
            o_mem_wdata_r <= '0;
            o_idle_r      <= 1'b1;
        end else begin
            o_idle_r <= !fifo_nempty && !i_init_busy_r && !i_init_wen_r
                        && (sel == SEL_NONE);
            case (sel)
                SEL_INIT: begin
                    o_mem_wen_r   <= 1'b1;
                    o_mem_waddr_r <= i_init_waddr_r;
                    o_mem_wdata_r <= i_init_wdata_r;
                end
                SEL_PIPE: begin
                    o_mem_wen_r   <= 1'b1;
                    o_mem_waddr_r <= head.addr;
                    o_mem_wdata_r <= head.data;
                end
                default: begin
                    o_mem_wen_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef STK_AL_WRARB_STATS_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_stat_pipe_wr_r <= '0;
            o_stat_stall_r   <= '0;
        end else begin
            if ((sel == SEL_PIPE) && (o_stat_pipe_wr_r != '1)) begin
                o_stat_pipe_wr_r <= o_stat_pipe_wr_r + 32'd1;
            end
            if (fifo_nempty && (sel != SEL_PIPE) && (o_stat_stall_r != '1)) begin
                o_stat_stall_r <= o_stat_stall_r + 32'd1;
            end
        end
    end
`endif

endmodule
